wallace_mult_sched: RTL



---
 rtl/wallace_pkg.sv | 15 +
 rtl/rr_arb2.sv | 46 ++++
 rtl/wallace_mult_sched.sv | 89 ++++++++
 3 files changed

// File: rtl/wallace_pkg.sv
// Shared types and defaults for the Wallace-tree multiplier scheduler.
package wallace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LAT   = 3;
  localparam int CNT_W     = 4;
  localparam int ID_W      = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with grant-on-accept pointer update.
// WALLACE_SCHED_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module rr_arb2
  import wallace_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef WALLACE_SCHED_RR_EN
  // ptr names the requester favoured on the next contention
  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (!ptr) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, rst, accept};

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`endif

endmodule

// File: rtl/wallace_mult_sched.sv
// Shares one combinational Wallace-tree multiplier between two requesters.
// Define WALLACE_SCHED_RR_EN for round-robin arbitration (default: fixed priority).
module wallace_mult_sched
  import wallace_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [2*WIDTH-1:0]   rsp_p,
  output logic                 busy
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic             accept;
  logic [ID_W-1:0]  win;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  // Ready is only offered from IDLE; rsp_ready never reaches this path.
  assign req_ready = (state == IDLE && !rst) ? gnt : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign win       = req_ready[1];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      case (state)
        // accept: tree operands are loaded here and held until the next accept
        IDLE: begin
          if (accept) begin
            mul_a  <= win[0] ? req_a1 : req_a0;
            mul_b  <= win[0] ? req_b1 : req_b0;
            rsp_id <= win;
            cnt    <= CNT_W'(LAT);
            state  <= WAIT;
          end
        end
        // settle: the tree output is trusted only after LAT edges
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        // respond: everything held until the consumer takes it
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
